// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC time-set constants, types and BCD helper
package rtc_pkg;

    localparam logic [3:0] FIELD_NONE  = 4'd0;
    localparam logic [3:0] FIELD_SEC   = 4'd1;
    localparam logic [3:0] FIELD_MIN   = 4'd2;
    localparam logic [3:0] FIELD_HOUR  = 4'd3;
    localparam logic [3:0] FIELD_DAY   = 4'd6;
    localparam logic [3:0] FIELD_MONTH = 4'd7;
    localparam logic [3:0] FIELD_YEAR  = 4'd8;

    localparam int TICK_DIV_DEFAULT = 26000000;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    // Only 0..99 is ever presented, so the quotient always fits one BCD digit.
    function automatic bcd2_t bin2bcd(input logic [6:0] b);
        bcd2_t r;
        r.tens  = 4'(b / 7'd10);
        r.units = 4'(b % 7'd10);
        return r;
    endfunction

endpackage

// File: rtl/contador_bcd_field_2dig_btn_repeat_tick.sv
// rtl/contador_bcd_field_2dig_btn_repeat_tick.sv - rising-edge step plus auto-repeat tick for one direction
module btn_repeat_tick #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic clr,
    output logic step
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic          w_edge;
    logic          w_rep;

    assign w_edge = req & ~r_prev;
    assign w_rep  = req & r_prev & (r_cnt == LAST);
    assign step   = ~clr & (w_edge | w_rep);

    // The edge register follows req even under clr, so a dropped step still consumes its edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= req;
            if (!req || clr || w_edge || w_rep)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/contador_bcd_field_2dig.sv
// rtl/contador_bcd_field_2dig.sv - 2-digit BCD up/down time-set counter for one RTC field
module contador_bcd_field_2dig
    import rtc_pkg::*;
#(
    parameter int FIELD_ID    = 6,
    parameter int MIN_VAL     = 1,
    parameter int MAX_VAL     = 31,
    parameter int TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int USE_DYN_MAX = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] en_count,
    input  logic       enUP,
    input  logic       enDOWN,
    input  logic       load,
    input  logic [3:0] load_digit1,
    input  logic [3:0] load_digit0,
    input  logic [6:0] dyn_max,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       wrap_up,
    output logic       wrap_down,
    output logic       load_err
);

    localparam int W = $clog2(MAX_VAL + 1);
    localparam logic [7:0] MIN8    = 8'(MIN_VAL);
    localparam logic [7:0] MIN8_P1 = 8'(MIN_VAL + 1);
    localparam logic [7:0] MAX8    = 8'(MAX_VAL);

    logic [W-1:0] r_value;
    logic         r_wrap_up;
    logic         r_wrap_down;
    logic         r_load_err;

    logic         w_sel;
    logic         w_req_up;
    logic         w_req_dn;
    logic         w_step_up;
    logic         w_step_dn;
    logic [7:0]   w_val8;
    logic [7:0]   w_dyn8;
    logic [7:0]   w_emax8;
    logic [7:0]   w_ld_val;
    logic         w_ld_ok;
    bcd2_t        w_bcd;

    assign w_sel    = (en_count == 4'(FIELD_ID));
    assign w_req_up = w_sel & enUP & ~enDOWN;
    assign w_req_dn = w_sel & enDOWN & ~enUP;

    btn_repeat_tick #(.TICK_DIV(TICK_DIV)) u_tick_up (
        .clk   (clk),
        .reset (reset),
        .req   (w_req_up),
        .clr   (load),
        .step  (w_step_up)
    );

    btn_repeat_tick #(.TICK_DIV(TICK_DIV)) u_tick_dn (
        .clk   (clk),
        .reset (reset),
        .req   (w_req_dn),
        .clr   (load),
        .step  (w_step_dn)
    );

    // Lower bounds are written as "x + 1 > MIN" so MIN_VAL = 0 needs no special case.
    assign w_val8  = 8'(r_value);
    assign w_dyn8  = {1'b0, dyn_max};
    assign w_emax8 = ((USE_DYN_MAX != 0) && (w_dyn8 + 8'd1 > MIN8) && (w_dyn8 <= MAX8))
                     ? w_dyn8 : MAX8;

    assign w_ld_val = 8'(load_digit1) * 8'd10 + 8'(load_digit0);
    assign w_ld_ok  = (load_digit1 <= 4'd9) && (load_digit0 <= 4'd9) &&
                      (w_ld_val + 8'd1 > MIN8) && (w_ld_val <= w_emax8);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value     <= W'(MIN_VAL);
            r_wrap_up   <= 1'b0;
            r_wrap_down <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_wrap_up   <= 1'b0;
            r_wrap_down <= 1'b0;
            r_load_err  <= 1'b0;
            if (load) begin
                if (w_ld_ok)
                    r_value <= W'(w_ld_val);
                else
                    r_load_err <= 1'b1;
            end else if (w_step_up) begin
                if (w_val8 >= w_emax8) begin
                    r_value   <= W'(MIN_VAL);
                    r_wrap_up <= 1'b1;
                end else begin
                    r_value <= W'(w_val8 + 8'd1);
                end
            end else if (w_step_dn) begin
                if (w_val8 < MIN8_P1) begin
                    r_value     <= W'(w_emax8);
                    r_wrap_down <= 1'b1;
                end else begin
                    r_value <= W'(w_val8 - 8'd1);
                end
            end else if (w_val8 > w_emax8) begin
                r_value <= W'(w_emax8);
            end
        end
    end

    assign w_bcd     = bin2bcd(7'(r_value));
    assign digit1    = w_bcd.tens;
    assign digit0    = w_bcd.units;
    assign wrap_up   = r_wrap_up;
    assign wrap_down = r_wrap_down;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_contador_bcd_field_2dig.sv
// tb/tb_contador_bcd_field_2dig.sv - self-checking bench for contador_bcd_field_2dig
module tb_contador_bcd_field_2dig;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic [3:0] a_en = 4'd0;
    logic       a_up = 1'b0, a_dn = 1'b0, a_ld = 1'b0;
    logic [3:0] a_d1i = 4'd0, a_d0i = 4'd0;
    logic [6:0] a_dmax = 7'd31;
    logic [3:0] a_d1, a_d0;
    logic       a_wu, a_wd, a_le;

    logic       b_up = 1'b0, b_dn = 1'b0, b_ld = 1'b0;
    logic [3:0] b_d1i = 4'd0, b_d0i = 4'd0;
    logic [3:0] b_d1, b_d0;
    logic       b_wu, b_wd, b_le;

    int tests = 0;
    int fails = 0;

    int m_val;
    bit m_pu, m_pd, m_wu, m_wd, m_le;
    int m_nu, m_nd;

    always #5 clk = ~clk;

    contador_bcd_field_2dig #(
        .FIELD_ID(6), .MIN_VAL(1), .MAX_VAL(31), .TICK_DIV(TD), .USE_DYN_MAX(1)
    ) dut_a (
        .clk(clk), .reset(reset), .en_count(a_en), .enUP(a_up), .enDOWN(a_dn),
        .load(a_ld), .load_digit1(a_d1i), .load_digit0(a_d0i), .dyn_max(a_dmax),
        .digit1(a_d1), .digit0(a_d0), .wrap_up(a_wu), .wrap_down(a_wd), .load_err(a_le)
    );

    contador_bcd_field_2dig #(
        .FIELD_ID(6), .MIN_VAL(0), .MAX_VAL(59), .TICK_DIV(TD), .USE_DYN_MAX(0)
    ) dut_b (
        .clk(clk), .reset(reset), .en_count(4'd6), .enUP(b_up), .enDOWN(b_dn),
        .load(b_ld), .load_digit1(b_d1i), .load_digit0(b_d0i), .dyn_max(7'd10),
        .digit1(b_d1), .digit0(b_d0), .wrap_up(b_wu), .wrap_down(b_wd), .load_err(b_le)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val = 1;
        m_pu = 0; m_pd = 0; m_nu = 0; m_nd = 0;
        m_wu = 0; m_wd = 0; m_le = 0;
    endtask

    // Reference: steps fall on every TD-th cycle counted from the press (or from a load).
    task automatic model_a(input int en, input bit up, input bit dn, input bit ld,
                           input int d1, input int d0, input int dmax);
        bit ru, rd, su, sd;
        int emax, v;
        ru = (en == 6) && up && !dn;
        rd = (en == 6) && dn && !up;
        emax = (dmax >= 1 && dmax <= 31) ? dmax : 31;
        m_nu = (ru && !m_pu) || ld ? 0 : m_nu + 1;
        m_nd = (rd && !m_pd) || ld ? 0 : m_nd + 1;
        su = ru && !ld && (!m_pu || (m_nu % TD == 0));
        sd = rd && !ld && (!m_pd || (m_nd % TD == 0));
        m_pu = ru;
        m_pd = rd;
        m_wu = 0; m_wd = 0; m_le = 0;
        if (ld) begin
            v = 10 * d1 + d0;
            if (d1 <= 9 && d0 <= 9 && v >= 1 && v <= emax) m_val = v;
            else m_le = 1;
        end else if (su) begin
            if (m_val >= emax) begin m_val = 1; m_wu = 1; end
            else m_val = m_val + 1;
        end else if (sd) begin
            if (m_val <= 1) begin m_val = emax; m_wd = 1; end
            else m_val = m_val - 1;
        end else if (m_val > emax) begin
            m_val = emax;
        end
    endtask

    task automatic cyc_a(input int en, input bit up, input bit dn, input bit ld,
                         input int d1, input int d0, input int dmax);
        @(negedge clk);
        a_en = 4'(en); a_up = up; a_dn = dn; a_ld = ld;
        a_d1i = 4'(d1); a_d0i = 4'(d0); a_dmax = 7'(dmax);
        model_a(en, up, dn, ld, d1, d0, dmax);
        @(posedge clk);
        #1;
        check("a_digit1", a_d1, m_val / 10);
        check("a_digit0", a_d0, m_val % 10);
        check("a_wrap_up", a_wu, m_wu);
        check("a_wrap_down", a_wd, m_wd);
        check("a_load_err", a_le, m_le);
    endtask

    task automatic cyc_b(input bit up, input bit dn, input bit ld, input int d1, input int d0);
        @(negedge clk);
        b_up = up; b_dn = dn; b_ld = ld; b_d1i = 4'(d1); b_d0i = 4'(d0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int en, dmax, d1, d0;
        bit up, dn, ld;
        model_reset();
        #12;
        check("reset_a_digit1", a_d1, 0);
        check("reset_a_digit0", a_d0, 1);
        check("reset_b_digit0", b_d0, 0);
        @(negedge clk);
        reset = 1'b0;

        cyc_a(0, 0, 0, 1, 1, 7, 31);
        check("load17", {a_d1, a_d0}, {4'd1, 4'd7});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_digits", {a_d1, a_d0}, {4'd0, 4'd1});
        check("async_reset_wraps", {a_wu, a_wd}, 2'b00);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        cyc_a(6, 0, 0, 1, 3, 1, 31);
        cyc_a(6, 1, 0, 0, 0, 0, 31);
        check("wrap_31_to_1", {a_d1, a_d0, 3'(a_wu)}, {4'd0, 4'd1, 3'd1});
        cyc_a(6, 0, 0, 0, 0, 0, 31);
        check("wrap_up_one_cycle", a_wu, 0);

        cyc_a(5, 0, 0, 1, 3, 1, 31);
        cyc_a(5, 1, 0, 0, 0, 0, 31);
        check("deselected_no_step", {a_d1, a_d0}, {4'd3, 4'd1});
        cyc_a(5, 0, 0, 0, 0, 0, 31);

        cyc_a(6, 0, 0, 1, 0, 1, 31);
        for (int i = 0; i < 13; i++) cyc_a(6, 1, 0, 0, 0, 0, 31);
        check("hold13_value5", {a_d1, a_d0}, {4'd0, 4'd5});
        for (int i = 0; i < 6; i++) cyc_a(6, 1, 1, 0, 0, 0, 31);
        check("both_high_frozen", {a_d1, a_d0}, {4'd0, 4'd5});
        cyc_a(6, 0, 0, 0, 0, 0, 31);

        cyc_a(6, 0, 0, 1, 3, 1, 31);
        cyc_a(6, 0, 0, 0, 0, 0, 28);
        check("clamp_to_28", {a_d1, a_d0, 2'(a_wu), 2'(a_wd)}, {4'd2, 4'd8, 2'd0, 2'd0});
        cyc_a(6, 0, 0, 1, 0, 1, 28);
        cyc_a(6, 0, 1, 0, 0, 0, 28);
        check("down_wrap_to_28", {a_d1, a_d0, 3'(a_wd)}, {4'd2, 4'd8, 3'd1});
        cyc_a(6, 0, 0, 0, 0, 0, 31);

        cyc_a(6, 1, 0, 1, 2, 5, 31);
        check("load_beats_step", {a_d1, a_d0}, {4'd2, 4'd5});
        cyc_a(6, 0, 0, 0, 0, 0, 31);
        cyc_a(6, 0, 0, 1, 3, 2, 31);
        check("load32_rejected", {a_d1, a_d0, 3'(a_le)}, {4'd2, 4'd5, 3'd1});
        cyc_a(6, 0, 0, 1, 0, 10, 31);
        check("load0A_rejected", {a_d1, a_d0, 3'(a_le)}, {4'd2, 4'd5, 3'd1});

        up = 0; dn = 0; dmax = 31;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 4) == 0) ? 5 : 6;
            if ($urandom_range(0, 5) == 0) up = ~up;
            if ($urandom_range(0, 5) == 0) dn = ~dn;
            if ($urandom_range(0, 15) == 0) dmax = $urandom_range(0, 40);
            ld = ($urandom_range(0, 9) == 0);
            d1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            d0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            cyc_a(en, up, dn, ld, d1, d0, dmax);
        end

        cyc_b(0, 0, 1, 5, 9);
        check("b_load59", {b_d1, b_d0, 3'(b_le)}, {4'd5, 4'd9, 3'd0});
        cyc_b(1, 0, 0, 0, 0);
        check("b_up_wrap_00", {b_d1, b_d0, 3'(b_wu)}, {4'd0, 4'd0, 3'd1});
        cyc_b(0, 0, 0, 0, 0);
        cyc_b(0, 1, 0, 0, 0);
        check("b_down_wrap_59", {b_d1, b_d0, 3'(b_wd)}, {4'd5, 4'd9, 3'd1});
        cyc_b(0, 0, 0, 0, 0);
        check("b_no_clamp", {b_d1, b_d0, 2'(b_wu), 2'(b_wd)}, {4'd5, 4'd9, 2'd0, 2'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
